// File: rtl/dtw_query_writer.sv
// rtl/dtw_query_writer.sv - frames a sample stream into fixed-length queries for the DTW source FIFO
//
// Each query is written as one header word (the query id) followed by exactly
// SQG_SIZE zero-extended sample words. Reads shorter than SQG_SIZE are padded
// with zero words (err_short); longer reads are truncated and the remainder of
// the read is drained and discarded (err_long).
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   en, qid_load       start request / query-id load (both honoured only in IDLE)
//   start_qid          query-id load value
//   s_axis_t*          sample stream in (sample in tdata[WIDTH-1:0])
//   src_fifo_*         source FIFO write port (wren, data) and full flag
//   busy               high outside IDLE
//   err_short/err_long one-cycle pulses for padded / truncated reads
//   dbg_state          current FSM state
//   dbg_nquery         number of queries fully written

module dtw_query_writer #(
    parameter int WIDTH      = 16,
    parameter int AXIS_WIDTH = 32,
    parameter int SQG_SIZE   = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  qid_load,
    input  logic [31:0]           start_qid,
    input  logic [AXIS_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic                  src_fifo_wren,
    input  logic                  src_fifo_full,
    output logic [31:0]           src_fifo_data,
    output logic                  busy,
    output logic                  err_short,
    output logic                  err_long,
    output logic [2:0]            dbg_state,
    output logic [31:0]           dbg_nquery
);

    localparam int CW = $clog2(SQG_SIZE + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(SQG_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_BODY  = 3'd2,
        ST_PAD   = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   qid_q, qid_d;
    logic [31:0]   nquery_q, nquery_d;
    logic          err_short_q, err_short_d;
    logic          err_long_q, err_long_d;

    logic          tready_c;
    logic          wren_c;
    logic [31:0]   data_c;
    logic          at_last;

    // Upper stream bits carry nothing for this block.
    logic unused_tdata;
    assign unused_tdata = ^s_axis_tdata;

    assign at_last = (count_q == LAST_CNT);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        qid_d       = qid_q;
        nquery_d    = nquery_q;
        err_short_d = 1'b0;
        err_long_d  = 1'b0;
        tready_c    = 1'b0;
        wren_c      = 1'b0;
        data_c      = 32'h0;

        case (state_q)
            ST_IDLE: begin
                // A load wins over a start; the start is retried next cycle.
                if (qid_load) begin
                    qid_d = start_qid;
                end else if (en && s_axis_tvalid) begin
                    state_d = ST_HDR;
                end
            end

            ST_HDR: begin
                wren_c = !src_fifo_full;
                data_c = qid_q;
                if (!src_fifo_full) begin
                    count_d = '0;
                    state_d = ST_BODY;
                end
            end

            ST_BODY: begin
                tready_c = !src_fifo_full;
                wren_c   = s_axis_tvalid && !src_fifo_full;
                data_c   = 32'(s_axis_tdata[WIDTH-1:0]);
                if (wren_c) begin
                    count_d = count_q + 1'b1;
                    if (at_last) begin
                        qid_d    = qid_q + 32'd1;
                        nquery_d = nquery_q + 32'd1;
                        state_d  = s_axis_tlast ? ST_IDLE : ST_DRAIN;
                    end else if (s_axis_tlast) begin
                        state_d = ST_PAD;
                    end
                end
            end

            ST_PAD: begin
                wren_c = !src_fifo_full;
                data_c = 32'h0;
                if (!src_fifo_full) begin
                    count_d = count_q + 1'b1;
                    if (at_last) begin
                        qid_d       = qid_q + 32'd1;
                        nquery_d    = nquery_q + 32'd1;
                        err_short_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end
            end

            ST_DRAIN: begin
                tready_c = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) begin
                    err_long_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            qid_q       <= 32'h0;
            nquery_q    <= 32'h0;
            err_short_q <= 1'b0;
            err_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            qid_q       <= qid_d;
            nquery_q    <= nquery_d;
            err_short_q <= err_short_d;
            err_long_q  <= err_long_d;
        end
    end

    // Outputs are forced quiet while rst is held, including the cycle before
    // the first reset edge when the flops are still unknown.
    assign s_axis_tready = !rst && tready_c;
    assign src_fifo_wren = !rst && wren_c;
    assign src_fifo_data = rst ? 32'h0 : data_c;
    assign busy          = !rst && (state_q != ST_IDLE);
    assign err_short     = !rst && err_short_q;
    assign err_long      = !rst && err_long_q;
    assign dbg_state     = state_q;
    assign dbg_nquery    = nquery_q;

endmodule

// File: tb/tb_dtw_query_writer.sv
// tb/tb_dtw_query_writer.sv - scoreboard bench for dtw_query_writer with SQG_SIZE=4

module tb_dtw_query_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        qid_load;
    logic [31:0] start_qid;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        src_fifo_wren;
    logic        src_fifo_full;
    logic [31:0] src_fifo_data;
    logic        busy;
    logic        err_short;
    logic        err_long;
    logic [2:0]  dbg_state;
    logic [31:0] dbg_nquery;

    int n_cmp = 0;
    int n_mis = 0;
    int n_short = 0;
    int n_long = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dtw_query_writer #(.WIDTH(16), .AXIS_WIDTH(32), .SQG_SIZE(4)) dut (
        .clk(clk), .rst(rst), .en(en), .qid_load(qid_load), .start_qid(start_qid),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .src_fifo_wren(src_fifo_wren), .src_fifo_full(src_fifo_full),
        .src_fifo_data(src_fifo_data), .busy(busy), .err_short(err_short),
        .err_long(err_long), .dbg_state(dbg_state), .dbg_nquery(dbg_nquery)
    );

    // Scoreboard monitor: every FIFO write is checked against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (src_fifo_wren && src_fifo_full) begin
                n_cmp++; n_mis++;
                $display("FAIL wren_while_full: wren=1 full=1, required wren=0");
            end
            if (src_fifo_wren) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_mis++;
                    $display("FAIL unexpected_write: got %h, required no write", src_fifo_data);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (src_fifo_data !== e) begin
                        n_mis++;
                        $display("FAIL fifo_word: got %h, required %h", src_fifo_data, e);
                    end
                end
            end
            if (err_short) n_short++;
            if (err_long) n_long++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one word and hold it until accepted.
    task automatic send_word(input logic [31:0] d, input logic last);
        bit hs;
        hs = 0;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        for (int i = 0; i < 100 && !hs; i++) begin
            @(negedge clk);
            if (s_axis_tready) hs = 1;
            tick();
        end
        if (!hs) begin
            n_cmp++; n_mis++;
            $display("FAIL handshake_timeout: data %h never accepted, required acceptance", d);
        end
    endtask

    // Sends a read of n samples (values base..base+n-1) with tlast on the final one.
    task automatic send_read(input logic [31:0] base, input int n);
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_word(base + 32'(i), i == n - 1);
            en = 1'b0;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (dbg_state == 3'd0) ok = 1;
        end
        n_cmp++;
        if (!ok) begin
            n_mis++;
            $display("FAIL idle_timeout: state=%0d, required 0", dbg_state);
        end
        tick();
    endtask

    task automatic load_qid(input logic [31:0] q);
        qid_load = 1'b1; start_qid = q;
        tick();
        qid_load = 1'b0;
    endtask

    task automatic check_end(input string name, input logic [31:0] nq,
                             input int es, input int el);
        n_cmp++;
        if (dbg_nquery !== nq) begin
            n_mis++;
            $display("FAIL %s_nquery: got %0d, required %0d", name, dbg_nquery, nq);
        end
        n_cmp++;
        if (n_short != es || n_long != el) begin
            n_mis++;
            $display("FAIL %s_err: got short=%0d long=%0d, required short=%0d long=%0d",
                     name, n_short, n_long, es, el);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL %s_pending: got %0d words outstanding, required 0", name, exp_q.size());
        end
        n_short = 0; n_long = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; qid_load = 1'b0; start_qid = 32'h0;
        s_axis_tdata = 32'h0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
        src_fifo_full = 1'b0;
        tick(); tick();
        @(negedge clk);
        n_cmp++;
        if ({busy, s_axis_tready, src_fifo_wren, err_short, err_long} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_flags: got %b, required 00000",
                     {busy, s_axis_tready, src_fifo_wren, err_short, err_long});
        end
        n_cmp++;
        if (src_fifo_data !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_data: got %h, required 0", src_fifo_data);
        end
        n_cmp++;
        if (dbg_state !== 3'd0 || dbg_nquery !== 32'h0) begin
            n_mis++;
            $display("FAIL reset_state: got state=%0d nq=%0d, required 0/0", dbg_state, dbg_nquery);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_full_query();
        load_qid(32'h10);
        exp_q.push_back(32'h10);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        send_read(32'd1, 4);
        wait_idle();
        check_end("full", 32'd1, 0, 0);
    endtask

    task automatic test_short();
        exp_q.push_back(32'h11);
        exp_q.push_back(32'd5); exp_q.push_back(32'd6);
        exp_q.push_back(32'd0); exp_q.push_back(32'd0);
        send_read(32'd5, 2);
        wait_idle();
        check_end("short", 32'd2, 1, 0);
    endtask

    task automatic test_long();
        exp_q.push_back(32'h12);
        for (int i = 1; i <= 4; i++) exp_q.push_back(32'(i));
        send_read(32'd1, 6);
        wait_idle();
        check_end("long", 32'd3, 0, 1);
    endtask

    task automatic test_full_stall();
        exp_q.push_back(32'h13);
        for (int i = 7; i <= 10; i++) exp_q.push_back(32'(i));
        fork
            send_read(32'd7, 4);
            begin
                bit in_body;
                in_body = 0;
                for (int i = 0; i < 50 && !in_body; i++) begin
                    @(negedge clk);
                    if (dbg_state == 3'd2) in_body = 1;
                end
                tick();
                src_fifo_full = 1'b1;
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (s_axis_tready !== 1'b0 || src_fifo_wren !== 1'b0 || dbg_state !== 3'd2) begin
                        n_mis++;
                        $display("FAIL stall_cycle%0d: got tready=%b wren=%b state=%0d, required 0/0/2",
                                 c, s_axis_tready, src_fifo_wren, dbg_state);
                    end
                    tick();
                end
                src_fifo_full = 1'b0;
            end
        join
        wait_idle();
        check_end("stall", 32'd4, 0, 0);
    endtask

    task automatic test_reset_mid();
        exp_q.push_back(32'h14);
        exp_q.push_back(32'd20); exp_q.push_back(32'd21);
        en = 1'b1;
        send_word(32'd20, 1'b0);
        en = 1'b0;
        send_word(32'd21, 1'b0);
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        n_short = 0; n_long = 0;
        exp_q.push_back(32'h0);
        for (int i = 30; i <= 33; i++) exp_q.push_back(32'(i));
        send_read(32'd30, 4);
        wait_idle();
        check_end("rst_mid", 32'd1, 0, 0);
    endtask

    task automatic test_wide_data();
        exp_q.push_back(32'h1);
        exp_q.push_back(32'h00001234);
        exp_q.push_back(32'h0); exp_q.push_back(32'h0); exp_q.push_back(32'h0);
        en = 1'b1;
        send_word(32'hABCD1234, 1'b1);
        en = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        wait_idle();
        check_end("wide", 32'd2, 1, 0);
    endtask

    task automatic test_back_to_back_wrap();
        load_qid(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        for (int i = 40; i <= 43; i++) exp_q.push_back(32'(i));
        send_read(32'd40, 4);
        exp_q.push_back(32'h0);
        for (int i = 50; i <= 53; i++) exp_q.push_back(32'(i));
        send_read(32'd50, 4);
        wait_idle();
        check_end("wrap", 32'd4, 0, 0);
    endtask

    initial begin
        test_reset();
        test_full_query();
        test_short();
        test_long();
        test_full_stall();
        test_reset_mid();
        test_wide_data();
        test_back_to_back_wrap();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
